seg_7_in: RTL
=============

# seg_7_in

Capture and decode block for a time-multiplexed, active-low 7-segment display bus. It is the receiving end of the segment encoder. It watches the segment lines and digit-select lines, waits for each digit to settle, and decodes the segment pattern back to a 4-bit hex value. Decoded digits are held in a register bank, invalid patterns are flagged, and a pulse marks each complete scan of all digits. It is used as a display monitor and self-check in board-level test designs.

## Interface
- DIGITS, 8: number of multiplexed digits, from 1 to 8.
- SETTLE, 4: consecutive identical samples required before capture, minimum 2.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  active-low segments; bit0 = a through bit6 = g.
- an_in  in  DIGITS  active-low digit select; exactly one bit low is a legal select.
- clear  in  1  synchronous clear of the captured state.
- hex_out  out  4*DIGITS  decoded values; digit d occupies bits [4d+3:4d].
- dig_valid  out  DIGITS  digit d holds a valid decode.
- err  out  DIGITS  last capture of digit d was an illegal pattern.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last frame or clear.

## Operation
- **Sample register:** `{seg_in, an_in}` is registered every cycle into `smp`. The stability counter `cnt` saturates at SETTLE.
  - If the new sample differs from `smp`, or `an_in` is not one-hot-low, `cnt` is set to 1 (0 when not one-hot).
  - Otherwise `cnt` increments.
- **Capture:** fires once per stable window, on the cycle `cnt` reaches SETTLE. There is no recapture until the sample changes.
- **Decode table (seg_in to value):**
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=B
  - 1000110=C, 0100001=D, 0000110=E, 0001110=F
- **Capture result for selected digit d:**
  - Legal pattern: hex_out[d] = value, dig_valid[d] = 1, err[d] = 0.
  - Blank pattern 1111111: dig_valid[d] = 0, err[d] = 0, hex_out[d] unchanged.
  - Any other pattern: dig_valid[d] = 0, err[d] = 1, hex_out[d] unchanged.
- **Frame tracking:** each capture, of any kind, sets bit d of the internal `seen` mask.
  - When `seen` becomes all ones, frame_done pulses for 1 cycle and `seen` is cleared in the same edge.
  - Capturing the same digit twice does not advance the frame.
- **clear:** zeroes hex_out, dig_valid, err, `seen` and `cnt`. A digit that is still held is recaptured after SETTLE further stable samples.
  - clear asserted together with a capture: clear wins, and that capture is discarded.
- **rst** has the same effect as clear, plus:
  - `smp` is set to all ones (blank, no digit selected).
  - frame_done is set to 0.
  - Reset mid-scan discards any partial frame.

## Timing
- **Reset values:** hex_out = 0, dig_valid = 0, err = 0, frame_done = 0.
- **Capture latency:** inputs are held constant before sampling edges E1..E_SETTLE. The outputs reflect the capture after edge E_SETTLE+1, so latency is SETTLE+1 cycles from the first sampling edge.
- **frame_done** asserts in the same cycle the completing digit's hex_out/dig_valid update becomes visible.
- **Short holds:** a digit held for fewer than SETTLE samples (glitch, ghosting during an anode change) is never captured.
- **Invalid selects:** an_in all ones or with more than one bit low never captures, and it resets stability.
- **Outputs** are registered; there is no combinational path from any input to any output.

## Test plan
1. **Reset:** assert rst for 2 cycles with arbitrary inputs. Required: hex_out = 0, dig_valid = 0, err = 0, frame_done = 0.
2. **Basic capture:** SETTLE=4, an_in = 8'hFE, seg_in = 0100100 held for 8 cycles. Required: hex_out[3:0] = 2 and dig_valid[0] = 1 exactly 5 edges after the first sample. No further changes and no frame_done.
3. **Glitch rejection:** seg_in = 0110000 on digit 1 for 3 cycles, then 1111001 for 4+ cycles. Required: only value 1 is captured into hex_out[7:4]; the value 3 never appears.
4. **Illegal pattern:** seg_in = 1111110 on digit 3. Required: err[3] = 1, dig_valid[3] = 0, hex_out[15:12] unchanged.
   - Then the legal pattern 0001110 on digit 3. Required: err[3] = 0, hex_out[15:12] = F.
5. **Full scan:** digits 0..7 show values 0..7, each held for 6 cycles. Required: hex_out = 32'h76543210, dig_valid = 8'hFF.
   - frame_done is a single pulse, coincident with the digit-7 update.
   - A second scan produces exactly one more pulse.
6. **Illegal select and clear priority:**
   - an_in = 8'hFC held for 10 cycles. Required: no capture.
   - clear pulsed on the capture edge of digit 4. Required: all outputs 0, digit 4 not captured; it is recaptured SETTLE samples later.

Source files
------------

// File: rtl/seg_7_in.sv
// Capture/decode monitor for a multiplexed active-low 7-segment bus.
// Waits for each digit select to settle, decodes it, and tracks complete scans.
module seg_7_in #(
   parameter int DIGITS = 8,
   parameter int SETTLE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     an_in,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   hex_out,
   output logic [DIGITS-1:0]     dig_valid,
   output logic [DIGITS-1:0]     err,
   output logic                  frame_done
);

   localparam int CW = $clog2(SETTLE + 1);
   localparam int SW = 7 + DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Returns {blank, legal, value}.
   function automatic logic [5:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = {2'b01, 4'h0};
         7'b1111001: decode = {2'b01, 4'h1};
         7'b0100100: decode = {2'b01, 4'h2};
         7'b0110000: decode = {2'b01, 4'h3};
         7'b0011001: decode = {2'b01, 4'h4};
         7'b0010010: decode = {2'b01, 4'h5};
         7'b0000010: decode = {2'b01, 4'h6};
         7'b1111000: decode = {2'b01, 4'h7};
         7'b0000000: decode = {2'b01, 4'h8};
         7'b0010000: decode = {2'b01, 4'h9};
         7'b0001000: decode = {2'b01, 4'hA};
         7'b0000011: decode = {2'b01, 4'hB};
         7'b1000110: decode = {2'b01, 4'hC};
         7'b0100001: decode = {2'b01, 4'hD};
         7'b0000110: decode = {2'b01, 4'hE};
         7'b0001110: decode = {2'b01, 4'hF};
         7'b1111111: decode = {2'b10, 4'h0};
         default:    decode = {2'b00, 4'h0};
      endcase
   endfunction

   function automatic logic onehot_low(input logic [DIGITS-1:0] an);
      int n;
      n = 0;
      for (int i = 0; i < DIGITS; i++) begin
         n = n + (an[i] ? 0 : 1);
      end
      onehot_low = (n == 1);
   endfunction

   function automatic logic [IW-1:0] sel_index(input logic [DIGITS-1:0] an);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         idx = idx | (an[i] ? IW'(0) : IW'(i));
      end
      sel_index = idx;
   endfunction

   logic [SW-1:0]     smp;
   logic [CW-1:0]     cnt;
   logic              fire;
   logic [DIGITS-1:0] seen;

   logic [SW-1:0]     cur;
   logic [CW-1:0]     cnt_nxt;
   logic              fire_nxt;
   logic [5:0]        cap_dec;
   logic [IW-1:0]     cap_idx;
   logic [DIGITS-1:0] seen_nxt;
   logic              frame_hit;

   // Stability tracking and decode of the settled sample.
   always_comb begin
      cur = {seg_in, an_in};
      if (!onehot_low(an_in)) begin
         cnt_nxt = CW'(0);
      end else if (cur != smp) begin
         cnt_nxt = CW'(1);
      end else if (cnt == CW'(SETTLE)) begin
         cnt_nxt = cnt;
      end else begin
         cnt_nxt = cnt + CW'(1);
      end
      // fire marks the single cycle the window first becomes settled
      fire_nxt  = (cnt_nxt == CW'(SETTLE)) && (cnt != CW'(SETTLE));
      cap_dec   = decode(smp[SW-1:DIGITS]);
      cap_idx   = sel_index(smp[DIGITS-1:0]);
      seen_nxt  = seen | ~smp[DIGITS-1:0];
      frame_hit = (seen_nxt == {DIGITS{1'b1}});
   end

   // Sample register, capture bank and frame tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         smp        <= {SW{1'b1}};
         cnt        <= CW'(0);
         fire       <= 1'b0;
         seen       <= '0;
         hex_out    <= '0;
         dig_valid  <= '0;
         err        <= '0;
         frame_done <= 1'b0;
      end else begin
         smp        <= cur;
         frame_done <= 1'b0;
         if (clear) begin
            cnt       <= CW'(0);
            fire      <= 1'b0;
            seen      <= '0;
            hex_out   <= '0;
            dig_valid <= '0;
            err       <= '0;
         end else begin
            cnt  <= cnt_nxt;
            fire <= fire_nxt;
            if (fire) begin
               if (cap_dec[4]) begin
                  hex_out[4*cap_idx +: 4] <= cap_dec[3:0];
                  dig_valid[cap_idx]      <= 1'b1;
                  err[cap_idx]            <= 1'b0;
               end else begin
                  dig_valid[cap_idx]      <= 1'b0;
                  err[cap_idx]            <= !cap_dec[5];
               end
               if (frame_hit) begin
                  seen       <= '0;
                  frame_done <= 1'b1;
               end else begin
                  seen       <= seen_nxt;
               end
            end
         end
      end
   end

endmodule
